svn_scan_ctrl: RTL and testbench

SVN_SCAN_CTRL -- requirements
Module: svn_scan_ctrl

---
 rtl/svn_pkg.sv | 52 +++++
 rtl/svn_seg_enc.sv | 11 +
 rtl/svn_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_svn_scan_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/svn_pkg.sv
// Shared constants for the seven-segment scan controller: segment codes
// (active-low {CA..CG}, CA in bit 6) and output polarity values.
package svn_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic AN_ON  = 1'b0;
   localparam logic AN_OFF = 1'b1;
   localparam logic DP_ON  = 1'b0;
   localparam logic DP_OFF = 1'b1;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = SEG_0;
         4'h1:    code = SEG_1;
         4'h2:    code = SEG_2;
         4'h3:    code = SEG_3;
         4'h4:    code = SEG_4;
         4'h5:    code = SEG_5;
         4'h6:    code = SEG_6;
         4'h7:    code = SEG_7;
         4'h8:    code = SEG_8;
         4'h9:    code = SEG_9;
         4'hA:    code = SEG_A;
         4'hB:    code = SEG_B;
         4'hC:    code = SEG_C;
         4'hD:    code = SEG_D;
         4'hE:    code = SEG_E;
         4'hF:    code = SEG_F;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/svn_seg_enc.sv
// Combinational hex nibble to active-low seven-segment code.
module svn_seg_enc
   import svn_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/svn_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, frame-synchronous
// double-buffered display data, optional leading-zero suppression, registered outputs.
module svn_scan_ctrl
   import svn_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000,
   parameter int LZ_BLANK   = 0
) (
   input  logic                    clk,
   input  logic                    sys_rst_n,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  pend_q, pend_d;
   logic [DW-1:0]         pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
   logic [DW-1:0]         shd_data_q, shd_data_d;
   logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
   logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  wrap_q;
   logic                  frame_done_q;

   logic                  tick_s;
   logic                  wrap_s;
   logic [NUM_DIGITS-1:0] lz_mask_s;
   logic                  hi_zero_s;
   logic [3:0]            sel_nib_s;
   logic                  sel_dp_s;
   logic                  sel_blank_s;
   logic [6:0]            enc_seg_s;

   // Prescaler and digit index advance
   always_comb begin
      tick_s = (presc_q == PRESC_LAST);
      wrap_s = tick_s && (idx_q == IDX_LAST);
      if (tick_s) begin
         presc_d = {PW{1'b0}};
      end else begin
         presc_d = presc_q + PW'(1);
      end
      if (wrap_s) begin
         idx_d = {IW{1'b0}};
      end else if (tick_s) begin
         idx_d = idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
   end

   // Pending/shadow buffering: new data only reaches the display at a frame boundary
   always_comb begin
      pend_d       = pend_q;
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      shd_data_d   = shd_data_q;
      shd_dp_d     = shd_dp_q;
      shd_blank_d  = shd_blank_q;
      if (wrap_s) begin
         pend_d = 1'b0;
         if (load) begin
            shd_data_d  = data;
            shd_dp_d    = dp_in;
            shd_blank_d = blank;
         end else if (pend_q) begin
            shd_data_d  = pend_data_q;
            shd_dp_d    = pend_dp_q;
            shd_blank_d = pend_blank_q;
         end else begin
            shd_data_d  = shd_data_q;
         end
      end else if (load) begin
         pend_d       = 1'b1;
         pend_data_d  = data;
         pend_dp_d    = dp_in;
         pend_blank_d = blank;
      end else begin
         pend_d = pend_q;
      end
   end

   // Leading-zero mask (scanned from the most significant digit) and digit mux
   always_comb begin
      hi_zero_s = 1'b1;
      lz_mask_s = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         hi_zero_s    = hi_zero_s & (shd_data_q[4*i +: 4] == 4'h0);
         lz_mask_s[i] = (LZ_BLANK != 0) && (i > 0) && hi_zero_s && !shd_dp_q[i];
      end
      sel_nib_s   = shd_data_q[4*idx_q +: 4];
      sel_dp_s    = shd_dp_q[idx_q];
      sel_blank_s = shd_blank_q[idx_q] | lz_mask_s[idx_q];
   end

   svn_seg_enc u_seg_enc (
      .nib_i (sel_nib_s),
      .seg_o (enc_seg_s)
   );

   // Next output values; a dark digit keeps its anode off as well
   always_comb begin
      seg_d = SEG_BLANK;
      dp_d  = DP_OFF;
      an_d  = {NUM_DIGITS{AN_OFF}};
      if (sel_blank_s) begin
         seg_d = SEG_BLANK;
         dp_d  = DP_OFF;
      end else begin
         seg_d       = enc_seg_s;
         dp_d        = sel_dp_s ? DP_ON : DP_OFF;
         an_d[idx_q] = AN_ON;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         presc_q      <= {PW{1'b0}};
         idx_q        <= {IW{1'b0}};
         pend_q       <= 1'b0;
         pend_data_q  <= {DW{1'b0}};
         pend_dp_q    <= {NUM_DIGITS{1'b0}};
         pend_blank_q <= {NUM_DIGITS{1'b1}};
         shd_data_q   <= {DW{1'b0}};
         shd_dp_q     <= {NUM_DIGITS{1'b0}};
         shd_blank_q  <= {NUM_DIGITS{1'b1}};
         seg_q        <= SEG_BLANK;
         dp_q         <= DP_OFF;
         an_q         <= {NUM_DIGITS{AN_OFF}};
         wrap_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         shd_data_q   <= shd_data_d;
         shd_dp_q     <= shd_dp_d;
         shd_blank_q  <= shd_blank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         // wrap is delayed once more so the pulse lines up with the registered anodes
         wrap_q       <= wrap_s;
         frame_done_q <= wrap_q;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// Directed bench for svn_scan_ctrl: 4-digit instances with and without
// leading-zero suppression, plus a 1-digit instance scanning every cycle.
module tb_svn_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic        load;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic [3:0]  an_a, an_b;
   logic        fd_a, fd_b;

   logic [3:0]  data_c;
   logic        dp_in_c, blank_c, load_c;
   logic [6:0]  seg_c;
   logic        dp_c, an_c, fd_c;

   svn_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(0)) dut_a (
      .clk(clk), .sys_rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
   );

   svn_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(1)) dut_b (
      .clk(clk), .sys_rst_n(rst_n), .data(data), .dp_in(dp_in), .blank(blank), .load(load),
      .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
   );

   svn_scan_ctrl #(.NUM_DIGITS(1), .SCAN_DIV(1), .LZ_BLANK(0)) dut_c (
      .clk(clk), .sys_rst_n(rst_n), .data(data_c), .dp_in(dp_in_c), .blank(blank_c), .load(load_c),
      .seg(seg_c), .dp(dp_c), .an(an_c), .frame_done(fd_c)
   );

   typedef struct {
      logic [15:0] dat;
      logic [3:0]  dpi;
      logic [3:0]  blk;
      logic [27:0] seg;    // expected {d3,d2,d1,d0} with LZ_BLANK=0
      logic [3:0]  dpo;    // expected dp output per digit with LZ_BLANK=0
      logic [3:0]  dark;   // digits dark with LZ_BLANK=0
      logic [3:0]  lzdark; // additional digits dark with LZ_BLANK=1
   } vec_t;

   vec_t vecs [8];
   int   n_pass  = 0;
   int   n_total = 0;
   int   edge_k  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, exp, edge_k);
   endtask

   function automatic logic [6:0] code(input logic [3:0] n);
      logic [6:0] c;
      case (n)
         4'h0: c = 7'b0000001;  4'h1: c = 7'b1001111;  4'h2: c = 7'b0010010;  4'h3: c = 7'b0000110;
         4'h4: c = 7'b1001100;  4'h5: c = 7'b0100100;  4'h6: c = 7'b0100000;  4'h7: c = 7'b0001111;
         4'h8: c = 7'b0000000;  4'h9: c = 7'b0000100;  4'hA: c = 7'b0001000;  4'hB: c = 7'b1100000;
         4'hC: c = 7'b0110001;  4'hD: c = 7'b1000010;  4'hE: c = 7'b0110000;  4'hF: c = 7'b0111000;
         default: c = 7'b1111111;
      endcase
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      edge_k++;
   endtask

   task automatic check_reset_vals();
      chk("rst_seg_a", 16'(seg_a), 16'h007F);
      chk("rst_dp_a",  16'(dp_a),  16'h0001);
      chk("rst_an_a",  16'(an_a),  16'h000F);
      chk("rst_fd_a",  16'(fd_a),  16'h0000);
      chk("rst_seg_b", 16'(seg_b), 16'h007F);
      chk("rst_an_b",  16'(an_b),  16'h000F);
      chk("rst_an_c",  16'(an_c),  16'h0001);
      chk("rst_fd_c",  16'(fd_c),  16'h0000);
   endtask

   // Dark display after reset: frame_done on edges 13, 25, ... (4 digits x 3 clocks)
   task automatic check_idle();
      logic fd_exp;
      fd_exp = (edge_k >= 13) && (((edge_k - 1) % 12) == 0);
      chk("idle_seg_a", 16'(seg_a), 16'h007F);
      chk("idle_an_a",  16'(an_a),  16'h000F);
      chk("idle_dp_a",  16'(dp_a),  16'h0001);
      chk("idle_fd_a",  16'(fd_a),  16'(fd_exp));
      chk("idle_fd_b",  16'(fd_b),  16'(fd_exp));
      chk("idle_fd_c",  16'(fd_c),  16'(edge_k >= 2));
      chk("idle_an_c",  16'(an_c),  16'h0001);
   endtask

   task automatic wait_fd(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!fd_a && n < 40);
      chk({tag, "_fd_seen"}, 16'(fd_a), 16'h0001);
   endtask

   // Called in the cycle frame_done is high; walks digits 0..3, 3 clocks apart
   task automatic check_frame(input vec_t v, input string tag);
      logic [3:0] an_exp;
      logic       dk;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            step(); step(); step();
         end
         an_exp = 4'hF;
         if (!v.dark[i]) an_exp[i] = 1'b0;
         chk({tag, "_seg_a"}, 16'(seg_a), 16'(v.seg[7*i +: 7]));
         chk({tag, "_dp_a"},  16'(dp_a),  16'(v.dpo[i]));
         chk({tag, "_an_a"},  16'(an_a),  16'(an_exp));
         dk = v.dark[i] | v.lzdark[i];
         an_exp = 4'hF;
         if (!dk) an_exp[i] = 1'b0;
         chk({tag, "_seg_b"}, 16'(seg_b), dk ? 16'h007F : 16'(v.seg[7*i +: 7]));
         chk({tag, "_dp_b"},  16'(dp_b),  dk ? 16'h0001 : 16'(v.dpo[i]));
         chk({tag, "_an_b"},  16'(an_b),  16'(an_exp));
      end
   endtask

   initial begin
      vec_t  v;
      logic  blk_prev, dp_prev;
      logic [3:0] nib_prev;

      vecs[0] = '{16'h12AF, 4'b0100, 4'b0000,
                  {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011, 4'b0000, 4'b0000};
      vecs[1] = '{16'h0050, 4'b0000, 4'b0000,
                  {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111, 4'b0000, 4'b1100};
      vecs[2] = '{16'h0050, 4'b1000, 4'b0000,
                  {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b0111, 4'b0000, 4'b0100};
      vecs[3] = '{16'h3456, 4'b0011, 4'b0100,
                  {7'b0000110, 7'b1111111, 7'b0100100, 7'b0100000}, 4'b1100, 4'b0100, 4'b0000};
      vecs[4] = '{16'h789B, 4'b0000, 4'b0000,
                  {7'b0001111, 7'b0000000, 7'b0000100, 7'b1100000}, 4'b1111, 4'b0000, 4'b0000};
      vecs[5] = '{16'hCDE0, 4'b0000, 4'b0000,
                  {7'b0110001, 7'b1000010, 7'b0110000, 7'b0000001}, 4'b1111, 4'b0000, 4'b0000};
      vecs[6] = '{16'h0000, 4'b0000, 4'b0000,
                  {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111, 4'b0000, 4'b1110};
      vecs[7] = '{16'h4000, 4'b0000, 4'b0000,
                  {7'b1001100, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111, 4'b0000, 4'b0000};

      data = 16'h0000; dp_in = 4'b0000; blank = 4'b0000; load = 1'b0;
      data_c = 4'h0; dp_in_c = 1'b0; blank_c = 1'b0; load_c = 1'b0;

      // Reset, then idle: dark display, regular frame_done
      rst_n = 1'b0;
      step(); step();
      check_reset_vals();
      rst_n = 1'b1;
      edge_k = 0;
      for (int i = 0; i < 26; i++) begin
         step();
         check_idle();
      end

      // Two loads before the wrap: last one wins, display unchanged until the wrap
      data = 16'h1111; load = 1'b1;
      step();
      data = 16'h2222;
      step();
      load = 1'b0;
      for (int n = 0; n < 40 && !fd_a; n++) begin
         step();
         if (!fd_a) chk("hold_seg_a", 16'(seg_a), 16'h007F);
      end
      chk("two_load_fd_seen", 16'(fd_a), 16'h0001);
      v = '{16'h2222, 4'b0000, 4'b0000, {4{7'b0010010}}, 4'b1111, 4'b0000, 4'b0000};
      check_frame(v, "last_wins");

      // Table of display patterns, each loaded mid-frame
      for (int t = 0; t < 8; t++) begin
         data = vecs[t].dat; dp_in = vecs[t].dpi; blank = vecs[t].blk; load = 1'b1;
         step();
         load = 1'b0;
         wait_fd($sformatf("vec%0d", t));
         check_frame(vecs[t], $sformatf("vec%0d", t));
      end

      // Load coincident with the wrap tick goes straight into the new frame
      wait_fd("wrapload");
      for (int i = 0; i < 10; i++) step();
      data = 16'h3333; dp_in = 4'b0000; blank = 4'b0000; load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("wrapload_fd", 16'(fd_a), 16'h0001);
      v = '{16'h3333, 4'b0000, 4'b0000, {4{7'b0000110}}, 4'b1111, 4'b0000, 4'b0000};
      check_frame(v, "wrapload");

      // Reset while idx=2 with a load pending: pending discarded, display stays dark
      wait_fd("midrst");
      data = 16'h4444; load = 1'b1;
      step();
      load = 1'b0;
      step(); step(); step(); step();
      rst_n = 1'b0;
      step();
      check_reset_vals();
      rst_n = 1'b1;
      edge_k = 0;
      for (int i = 0; i < 26; i++) begin
         step();
         check_idle();
      end

      // Single digit, SCAN_DIV=1: seg follows the loaded nibble one cycle later
      blk_prev = 1'b1; dp_prev = 1'b0; nib_prev = 4'h0;
      for (int j = 0; j < 17; j++) begin
         data_c  = 4'(j * 7 + 3);
         dp_in_c = j[0];
         blank_c = (j == 9);
         load_c  = (j < 16);
         step();
         chk("c_seg", 16'(seg_c), blk_prev ? 16'h007F : 16'(code(nib_prev)));
         chk("c_dp",  16'(dp_c),  blk_prev ? 16'h0001 : 16'(!dp_prev));
         chk("c_an",  16'(an_c),  16'(blk_prev));
         chk("c_fd",  16'(fd_c),  16'h0001);
         blk_prev = blank_c; dp_prev = dp_in_c; nib_prev = data_c;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
